// File: rtl/program_sequencer.sv
// Fetch/execute controller: holds the PC, fetches instruction words over req/ack, strobes execute.
// Latency: min 2 cycles per instruction (FETCH with same-cycle ack, then one EXEC cycle).
// Backpressure: waits in FETCH with PM_Req high and PC stable until PM_Ack; no timeout.
//
// Ports:
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Halt_Req     begin/resume fetching; request a stop after the current instruction
//   Jump_En, Jump_Addr  branch request and target, honoured only in EXEC
//   PM_Addr, PM_Req     program memory address (always PC) and fetch request
//   PM_Ack, PM_Data     memory response: word valid this cycle
//   Ins, Exec_En        latched instruction and one-cycle execute strobe for the decoder
//   Busy, Halted        status: FETCH/EXEC, HALT
//   Retired             saturating count of executed instructions
module program_sequencer #(
  parameter int PC_W     = 8,
  parameter int INS_W    = 15,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Halt_Req,
  input  logic             Jump_En,
  input  logic [PC_W-1:0]  Jump_Addr,
  output logic [PC_W-1:0]  PM_Addr,
  output logic             PM_Req,
  input  logic             PM_Ack,
  input  logic [INS_W-1:0] PM_Data,
  output logic [INS_W-1:0] Ins,
  output logic             Exec_En,
  output logic             Busy,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc;
  logic             halt_pend;

  // Outputs decode straight from the state register so a reset assertion
  // drops PM_Req and Exec_En in the same cycle.
  assign PM_Addr = pc;
  assign PM_Req  = (state == S_FETCH);
  assign Exec_En = (state == S_EXEC);
  assign Busy    = (state == S_FETCH) || (state == S_EXEC);
  assign Halted  = (state == S_HALT);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_FETCH;
      S_FETCH: if (PM_Ack) state_nxt = S_EXEC;
      // A Halt_Req arriving in EXEC itself also stops after this instruction.
      S_EXEC:  state_nxt = (halt_pend || Halt_Req) ? S_HALT : S_FETCH;
      S_HALT:  if (Start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc        <= PC_W'(RESET_PC);
      Ins       <= '0;
      Retired   <= '0;
      halt_pend <= 1'b0;
    end else begin
      if (state == S_FETCH && PM_Ack) begin
        Ins <= PM_Data;
      end

      // halt_pend is only armed during FETCH, so Start+Halt_Req in HALT
      // resumes cleanly without a stale stop request.
      if (state == S_FETCH && Halt_Req) begin
        halt_pend <= 1'b1;
      end else if (state == S_EXEC && state_nxt == S_HALT) begin
        halt_pend <= 1'b0;
      end

      if (state == S_EXEC) begin
        // Increment wraps modulo 2^PC_W by natural overflow.
        pc <= Jump_En ? Jump_Addr : pc + PC_W'(1);
        if (Retired != {CNT_W{1'b1}}) begin
          Retired <= Retired + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: the bench acts as program memory and compares
// against a transaction-level model (expected PC, retired count, fetched word).
// All stimulus is driven and all outputs sampled on the falling clock edge.
module tb_program_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Halt_Req;
  logic        Jump_En;
  logic [7:0]  Jump_Addr;
  logic [7:0]  PM_Addr;
  logic        PM_Req;
  logic        PM_Ack;
  logic [14:0] PM_Data;
  logic [14:0] Ins;
  logic        Exec_En;
  logic        Busy;
  logic        Halted;
  logic [15:0] Retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  program_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Halt_Req(Halt_Req),
    .Jump_En(Jump_En), .Jump_Addr(Jump_Addr), .PM_Addr(PM_Addr), .PM_Req(PM_Req),
    .PM_Ack(PM_Ack), .PM_Data(PM_Data), .Ins(Ins), .Exec_En(Exec_En),
    .Busy(Busy), .Halted(Halted), .Retired(Retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Runs one instruction starting at a falling edge where the DUT is in FETCH.
  // dly: wait cycles before ack; halt_mode: 0 none, 1 Halt_Req in first fetch
  // cycle, 2 Halt_Req in EXEC; junk: toggle Jump/Start inputs during FETCH.
  task automatic do_instr(input int dly, input bit jmp, input logic [7:0] jaddr,
                          input int halt_mode, input bit junk);
    logic [14:0] w;
    w = mem[m_pc];
    for (int c = 0; c <= dly; c++) begin
      n_checks++;
      if (PM_Req !== 1'b1 || PM_Addr !== m_pc || Exec_En !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_cycle%0d: req=%b addr=%h exec=%b, want req=1 addr=%h exec=0",
                 c, PM_Req, PM_Addr, Exec_En, m_pc);
      end
      Halt_Req  = (halt_mode == 1 && c == 0);
      Jump_En   = junk;
      Jump_Addr = junk ? 8'($urandom) : 8'h00;
      Start     = junk ? 1'($urandom) : 1'b0;
      if (c == dly) begin
        PM_Ack  = 1'b1;
        PM_Data = w;
      end else begin
        PM_Ack  = 1'b0;
        PM_Data = 15'($urandom);
      end
      @(negedge Clk);
    end
    PM_Ack    = 1'b0;
    PM_Data   = 15'($urandom);
    Start     = 1'b0;
    Halt_Req  = (halt_mode == 2);
    Jump_En   = jmp;
    Jump_Addr = jaddr;
    n_checks++;
    if (Exec_En !== 1'b1 || PM_Req !== 1'b0 || Ins !== w || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL exec_cycle: exec=%b req=%b ins=%h busy=%b, want exec=1 req=0 ins=%h busy=1",
               Exec_En, PM_Req, Ins, Busy, w);
    end
    m_pc  = jmp ? jaddr : m_pc + 8'd1;
    m_ret = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
    @(negedge Clk);
    Halt_Req = 1'b0;
    Jump_En  = 1'b0;
    n_checks++;
    if (Exec_En !== 1'b0 || PM_Addr !== m_pc || Retired !== m_ret ||
        Halted !== (halt_mode != 0) || PM_Req !== (halt_mode == 0)) begin
      n_fail++;
      $display("FAIL after_exec: exec=%b addr=%h ret=%0d halted=%b req=%b, want exec=0 addr=%h ret=%0d halted=%b req=%b",
               Exec_En, PM_Addr, Retired, Halted, PM_Req, m_pc, m_ret,
               halt_mode != 0, halt_mode == 0);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; Halt_Req = 1'b0; Jump_En = 1'b0;
    Jump_Addr = 8'h00; PM_Ack = 1'b0; PM_Data = 15'h0;
    m_pc = 8'h00; m_ret = 16'h0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (PM_Req !== 1'b0 || Exec_En !== 1'b0 || Busy !== 1'b0 || Halted !== 1'b0 ||
        Retired !== 16'h0 || PM_Addr !== 8'h00 || Ins !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b exec=%b busy=%b halted=%b ret=%0d addr=%h ins=%h, want all zero",
               PM_Req, Exec_En, Busy, Halted, Retired, PM_Addr, Ins);
    end
    Rst_n = 1'b1;
    // Halt_Req in IDLE must be ignored; nothing starts without Start.
    Halt_Req = 1'b1;
    repeat (3) @(negedge Clk);
    Halt_Req = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || PM_Req !== 1'b0 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b req=%b halted=%b, want 0 0 0", Busy, PM_Req, Halted);
    end
  endtask

  task automatic test_back_to_back;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b, want 1", Busy);
    end
    for (int i = 0; i < 4; i++) do_instr(0, 1'b0, 8'h00, 0, 1'b0);
    n_checks++;
    if (Retired !== 16'd4) begin
      n_fail++;
      $display("FAIL retired_four: got %0d, want 4", Retired);
    end
  endtask

  task automatic test_ack_delay;
    do_instr(0, 1'b0, 8'h00, 0, 1'b0);   // address 4
    do_instr(3, 1'b0, 8'h00, 0, 1'b0);   // address 5, four fetch cycles
  endtask

  task automatic test_jump;
    do_instr(0, 1'b1, 8'h10, 0, 1'b0);
    // Jump stimulus during FETCH is ignored; the EXEC one is taken.
    Jump_En = 1'b1; Jump_Addr = 8'h40;
    do_instr(2, 1'b1, 8'h40, 0, 1'b1);
    n_checks++;
    if (PM_Addr !== 8'h40) begin
      n_fail++;
      $display("FAIL jump_target: addr=%h, want 40", PM_Addr);
    end
    do_instr(2, 1'b0, 8'h00, 0, 1'b1);
  endtask

  task automatic test_wrap;
    do_instr(0, 1'b1, 8'hFF, 0, 1'b0);
    do_instr(0, 1'b0, 8'h00, 0, 1'b0);
    n_checks++;
    if (PM_Addr !== 8'h00 || PM_Req !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h req=%b, want 00 1", PM_Addr, PM_Req);
    end
    do_instr(0, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_halt;
    do_instr(0, 1'b1, 8'h07, 0, 1'b0);
    do_instr(2, 1'b0, 8'h00, 1, 1'b0);
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Halted !== 1'b1 || Busy !== 1'b0 || PM_Addr !== 8'h08 || Retired !== m_ret) begin
      n_fail++;
      $display("FAIL halt_hold: halted=%b busy=%b addr=%h ret=%0d, want 1 0 08 %0d",
               Halted, Busy, PM_Addr, Retired, m_ret);
    end
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    do_instr(1, 1'b0, 8'h00, 2, 1'b0);   // halt requested in EXEC
    // Start and Halt_Req together: Start wins and no stop is left pending.
    Start = 1'b1; Halt_Req = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Halt_Req = 1'b0;
    do_instr(1, 1'b0, 8'h00, 0, 1'b0);
    do_instr(0, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      bit jmp;
      int hm;
      jmp = ($urandom_range(0, 3) == 0);
      hm  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_instr(int'($urandom_range(0, 4)), jmp, 8'($urandom), hm, 1'($urandom));
      if (hm != 0) begin
        repeat ($urandom_range(0, 3)) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    PM_Ack = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    m_pc = 8'h00; m_ret = 16'h0;
    n_checks++;
    if (PM_Req !== 1'b0 || PM_Addr !== 8'h00 || Retired !== 16'h0 || Exec_En !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b addr=%h ret=%0d exec=%b, want 0 00 0 0",
               PM_Req, PM_Addr, Retired, Exec_En);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || PM_Req !== 1'b0 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b req=%b halted=%b, want 0 0 0", Busy, PM_Req, Halted);
    end
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    do_instr(1, 1'b0, 8'h00, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 15'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 15'(i + 1);
    test_reset();
    test_back_to_back();
    test_ack_delay();
    test_jump();
    test_wrap();
    test_halt();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net: the run is bounded by the scenario loops, this only guards a stuck simulator.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
